// File: rtl/fir_cfg_ctrl_if.sv
// Pin-side configuration inputs and FIR-side control outputs of fir_cfg_ctrl.
// The master drives the slow coefficient pins; the slave is the controller.
interface fir_cfg_ctrl_if #(
    parameter int N_TAPS  = 10,
    parameter int BW_COEF = 4
);
    logic                        cfg_mode;
    logic                        cfg_stb;
    logic [BW_COEF-1:0]          cfg_data;
    logic [N_TAPS*BW_COEF-1:0]   coef;
    logic                        fir_clr;
    logic                        fir_en;
    logic                        cfg_done;
    logic [1:0]                  state;

    modport master (
        output cfg_mode, cfg_stb, cfg_data,
        input  coef, fir_clr, fir_en, cfg_done, state
    );

    modport slave (
        input  cfg_mode, cfg_stb, cfg_data,
        output coef, fir_clr, fir_en, cfg_done, state
    );
endinterface

// File: rtl/fir_cfg_ctrl.sv
// Coefficient loader and flush/sample-enable sequencer for the FIR datapath.
//   state | meaning
//   IDLE  | waiting for a configuration request
//   LOAD  | writing one coefficient per strobe rising edge
//   FLUSH | clearing the FIR delay line for N_TAPS cycles
//   RUN   | issuing one fir_en pulse every DIV cycles
module fir_cfg_ctrl #(
    parameter int N_TAPS  = 10,
    parameter int BW_COEF = 4,
    parameter int DIV     = 4
) (
    input  logic          clk,
    input  logic          rst,
    fir_cfg_ctrl_if.slave bus
);
    localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int DIV_W = $clog2(DIV);
    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(N_TAPS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        FLUSH = 2'b10,
        RUN   = 2'b11
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic                        mode_s1;
    logic                        mode_s;
    logic                        stb_s1;
    logic                        stb_s2;
    logic                        stb_s3;
    logic                        wr;
    logic                        load_write;
    logic                        load_entry;
    logic [N_TAPS*BW_COEF-1:0]   coef_q;
    logic [IDX_W-1:0]            idx;
    logic                        done_q;
    logic                        done_d;
    logic [IDX_W-1:0]            flush_cnt;
    logic [DIV_W-1:0]            div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_s1 <= 1'b0;
            mode_s  <= 1'b0;
            stb_s1  <= 1'b0;
            stb_s2  <= 1'b0;
            stb_s3  <= 1'b0;
        end else begin
            mode_s1 <= bus.cfg_mode;
            mode_s  <= mode_s1;
            stb_s1  <= bus.cfg_stb;
            stb_s2  <= stb_s1;
            stb_s3  <= stb_s2;
        end
    end

    // One pulse per strobe rising edge, independent of how long it is held.
    assign wr         = stb_s2 & ~stb_s3;
    assign load_write = (state_q == LOAD) && wr;
    // A write landing on the mode fall still decides FLUSH versus IDLE.
    assign done_d     = done_q | (load_write && (idx == LAST_TAP));
    assign load_entry = (state_d == LOAD) && (state_q != LOAD);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mode_s)
                    state_d = LOAD;
                else if (done_q)
                    state_d = FLUSH;
            end
            LOAD: begin
                if (!mode_s)
                    state_d = done_d ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (mode_s)
                    state_d = LOAD;
                else if (flush_cnt == LAST_TAP)
                    state_d = RUN;
            end
            RUN: begin
                if (mode_s)
                    state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_q <= '0;
            idx    <= '0;
            done_q <= 1'b0;
        end else if (load_entry) begin
            idx    <= '0;
            done_q <= 1'b0;
        end else if (load_write) begin
            for (int k = 0; k < N_TAPS; k++) begin
                if (idx == IDX_W'(k))
                    coef_q[k*BW_COEF +: BW_COEF] <= bus.cfg_data;
            end
            idx    <= (idx == LAST_TAP) ? '0 : idx + 1'b1;
            done_q <= done_d;
        end
    end

    // Counters rest at zero outside their state, so each entry starts from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
            div_cnt   <= '0;
        end else begin
            flush_cnt <= (state_q == FLUSH && state_d == FLUSH) ? flush_cnt + 1'b1 : '0;
            if (state_q == RUN && state_d == RUN)
                div_cnt <= (div_cnt == LAST_DIV) ? '0 : div_cnt + 1'b1;
            else
                div_cnt <= '0;
        end
    end

    assign bus.coef     = coef_q;
    assign bus.fir_clr  = (state_q == FLUSH);
    assign bus.fir_en   = (state_q == RUN) && (div_cnt == LAST_DIV);
    assign bus.cfg_done = done_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Directed bench for fir_cfg_ctrl: a table of pin steps with expected
// state/done/coef, plus hand sequences for flush, run, abort and reset.
module tb_fir_cfg_ctrl;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_LOAD  = 2'b01;
    localparam logic [1:0] S_FLUSH = 2'b10;
    localparam logic [1:0] S_RUN   = 2'b11;

    typedef struct {
        string       name;
        logic        mode;
        logic        stb;
        logic [3:0]  data;
        int          hold;
        logic [1:0]  exp_state;
        logic        exp_done;
        logic [39:0] exp_coef;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fir_cfg_ctrl_if #(.N_TAPS(10), .BW_COEF(4)) bus ();

    fir_cfg_ctrl #(.N_TAPS(10), .BW_COEF(4), .DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vecs[$];
    logic [39:0] exp_coef;
    int          clr_cnt;
    int          run_cyc;
    logic [2:0]  saw;
    int          first_partial;
    int          first_overrun;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic vec_t mk(input string name, input logic mode, input logic stb,
                                input logic [3:0] data, input int hold, input logic [1:0] st,
                                input logic done, input logic [39:0] coef);
        vec_t v;
        v.name = name; v.mode = mode; v.stb = stb; v.data = data; v.hold = hold;
        v.exp_state = st; v.exp_done = done; v.exp_coef = coef;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.cfg_mode = v.mode;
        if (v.stb) begin
            bus.cfg_data = v.data;
            bus.cfg_stb  = 1'b1;
            tick(v.hold);
            bus.cfg_stb  = 1'b0;
            tick(3);
        end else begin
            tick(3);
        end
        check(v.name, {bus.state, bus.cfg_done, bus.coef}, {v.exp_state, v.exp_done, v.exp_coef});
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(vecs[i]);
    endtask

    task automatic quiet_window(input string name, input int n);
        saw = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (bus.fir_en)  saw[2] = 1'b1;
            if (bus.fir_clr) saw[1] = 1'b1;
            if (bus.state != S_IDLE) saw[0] = 1'b1;
        end
        check(name, 64'(saw), 64'd0);
    endtask

    task automatic strobe(input logic [3:0] d);
        bus.cfg_data = d;
        bus.cfg_stb  = 1'b1;
        tick(3);
        bus.cfg_stb  = 1'b0;
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full load 1..10 from reset; the third strobe is held for 20 cycles.
        vecs.push_back(mk("enter_load", 1, 0, 0, 0, S_LOAD, 0, 40'h0));
        exp_coef = '0;
        for (int k = 1; k <= 10; k++) begin
            exp_coef[(k-1)*4 +: 4] = 4'(k);
            vecs.push_back(mk($sformatf("load_%0d", k), 1, 1, 4'(k), (k == 3) ? 20 : 3,
                              S_LOAD, (k == 10), exp_coef));
        end
        // Partial reload keeps old taps, then an IDLE strobe must be ignored.
        first_partial = vecs.size();
        vecs.push_back(mk("reload",        1, 0, 4'h0, 0, S_LOAD, 0, 40'hA987654321));
        vecs.push_back(mk("partial_5",     1, 1, 4'h5, 3, S_LOAD, 0, 40'hA987654325));
        vecs.push_back(mk("partial_6",     1, 1, 4'h6, 3, S_LOAD, 0, 40'hA987654365));
        vecs.push_back(mk("partial_7",     1, 1, 4'h7, 3, S_LOAD, 0, 40'hA987654765));
        vecs.push_back(mk("partial_idle",  0, 0, 4'h0, 0, S_IDLE, 0, 40'hA987654765));
        vecs.push_back(mk("idle_strobe",   0, 1, 4'hF, 3, S_IDLE, 0, 40'hA987654765));
        // Overrun: 12 writes wrap back onto taps 0 and 1.
        first_overrun = vecs.size();
        exp_coef = 40'hA987654765;
        vecs.push_back(mk("over_enter", 1, 0, 4'h0, 0, S_LOAD, 0, exp_coef));
        for (int k = 1; k <= 12; k++) begin
            exp_coef[((k-1)%10)*4 +: 4] = 4'(k);
            vecs.push_back(mk($sformatf("over_%0d", k), 1, 1, 4'(k), 3, S_LOAD, (k >= 10), exp_coef));
        end

        bus.cfg_mode = 1'b0;
        bus.cfg_stb  = 1'b0;
        bus.cfg_data = '0;

        // Reset with random pins.
        #1 rst = 1'b1;
        bus.cfg_mode = 1'($urandom);
        bus.cfg_stb  = 1'($urandom);
        bus.cfg_data = 4'($urandom);
        tick(3);
        check("reset_outputs", {bus.coef, bus.fir_clr, bus.fir_en, bus.cfg_done, bus.state}, 64'd0);
        bus.cfg_mode = 1'b0;
        bus.cfg_stb  = 1'b0;
        bus.cfg_data = '0;
        #2 rst = 1'b0;
        quiet_window("idle_after_reset", 50);

        apply_range(0, first_partial - 1);

        // Flush and run from the full load.
        bus.cfg_mode = 1'b0;
        clr_cnt = 0;
        run_cyc = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.fir_clr) clr_cnt++;
            if (bus.state == S_RUN) begin
                run_cyc++;
                check($sformatf("run_fir_en_%0d", run_cyc), 64'(bus.fir_en), 64'(run_cyc % 4 == 0));
            end else begin
                check("pre_run_fir_en", 64'(bus.fir_en), 64'd0);
            end
        end
        check("flush_width", 64'(clr_cnt), 64'd10);
        check("run_cycles", 64'(run_cyc), 64'd48);
        check("coef_after_run", bus.coef, 40'hA987654321);

        apply_range(first_partial, first_overrun - 1);
        quiet_window("partial_stays_idle", 30);

        apply_range(first_overrun, vecs.size() - 1);
        check("overrun_coef", bus.coef, 40'hA9876543CB);

        // Abort mid-FLUSH.
        bus.cfg_mode = 1'b0;
        tick(3);
        check("abort_in_flush", {bus.state, bus.fir_clr}, {S_FLUSH, 1'b1});
        tick(2);
        bus.cfg_mode = 1'b1;
        tick(3);
        check("abort_to_load", {bus.state, bus.cfg_done, bus.fir_clr}, {S_LOAD, 1'b0, 1'b0});

        // Reload, run, then reset while fir_en is high.
        for (int k = 1; k <= 10; k++) strobe(4'(k));
        check("reload_done", {bus.cfg_done, bus.coef}, {1'b1, 40'hA987654321});
        bus.cfg_mode = 1'b0;
        tick(20);
        check("run_before_reset", {bus.state, bus.fir_en}, {S_RUN, 1'b1});
        #2 rst = 1'b1;
        #1;
        check("reset_mid_run", {bus.coef, bus.fir_clr, bus.fir_en, bus.cfg_done, bus.state}, 64'd0);
        tick(1);
        #2 rst = 1'b0;
        tick(3);
        check("idle_after_release", {bus.state, bus.cfg_done, bus.coef}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
